// File: rtl/cmp_serial.sv
// cmp_serial: bit-serial magnitude comparator.
// Captures x/y on an accepted start, then scans MSB-first one bit per clock,
// stopping at the first differing bit. Produces the same six relational flags
// as the parallel comparator, with a one-cycle done pulse on completion.
//
// Parameters:
//   WIDTH   operand width in bits (>= 2)
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start                   compare request (sampled only when idle)
//   x, y                    operands, captured on an accepted start
//   busy                    high while a scan is in progress
//   done                    one-cycle completion pulse
//   eq/neq/lt/lte/gt/gte    registered flags for x relative to y
module cmp_serial #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             neq,
    output logic             lt,
    output logic             lte,
    output logic             gt,
    output logic             gte
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state;
    logic [WIDTH-1:0] xr, yr;
    logic [IW-1:0]    idx;

    // Current-bit decision. For a signed compare a difference in the sign bit
    // means the operand with the 1 is the smaller one, so the sense flips.
    logic bit_diff;
    logic sign_pos;
    logic x_wins;

    always_comb begin
        bit_diff = xr[idx] ^ yr[idx];
        sign_pos = SIGNED && (idx == MSB_IDX);
        x_wins   = xr[idx] ^ sign_pos;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            xr    <= '0;
            yr    <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            neq   <= 1'b0;
            lt    <= 1'b0;
            lte   <= 1'b0;
            gt    <= 1'b0;
            gte   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        xr    <= x;
                        yr    <= y;
                        idx   <= MSB_IDX;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (bit_diff) begin
                        eq    <= 1'b0;
                        neq   <= 1'b1;
                        gt    <= x_wins;
                        gte   <= x_wins;
                        lt    <= ~x_wins;
                        lte   <= ~x_wins;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (idx == '0) begin
                        eq    <= 1'b1;
                        neq   <= 1'b0;
                        gt    <= 1'b0;
                        gte   <= 1'b1;
                        lt    <= 1'b0;
                        lte   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_serial.sv
// Directed bench for cmp_serial: an unsigned and a signed instance share the
// same stimulus; expected flags and latencies are hand-computed.
// Flag vector order: {eq, neq, lt, lte, gt, gte}.
module tb_cmp_serial;

    localparam logic [5:0] F_GT = 6'b010011;
    localparam logic [5:0] F_LT = 6'b011100;
    localparam logic [5:0] F_EQ = 6'b100101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x = '0, y = '0;

    logic busy_u, done_u, eq_u, neq_u, lt_u, lte_u, gt_u, gte_u;
    logic busy_s, done_s, eq_s, neq_s, lt_s, lte_s, gt_s, gte_s;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cmp_serial #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy_u), .done(done_u),
        .eq(eq_u), .neq(neq_u), .lt(lt_u), .lte(lte_u), .gt(gt_u), .gte(gte_u)
    );

    cmp_serial #(.WIDTH(8), .SIGNED(1'b1)) s_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
        .busy(busy_s), .done(done_s),
        .eq(eq_s), .neq(neq_s), .lt(lt_s), .lte(lte_s), .gt(gt_s), .gte(gte_s)
    );

    wire [5:0] flg_u = {eq_u, neq_u, lt_u, lte_u, gt_u, gte_u};
    wire [5:0] flg_s = {eq_s, neq_s, lt_s, lte_s, gt_s, gte_s};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one compare (caller is idle and just past an edge), wait for done
    // with a bounded cycle count, then check latency and both flag sets.
    task automatic run(input logic [7:0] xv, input logic [7:0] yv, input int lat,
                       input logic [5:0] fu, input logic [5:0] fs, input string tag);
        int n;
        x = xv; y = yv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x = ~xv;   // post-capture changes must not matter
        chk({tag, "_busy"}, {busy_u, busy_s}, 2'b11);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done_u) break;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_done_s"}, done_s, 1'b1);
        chk({tag, "_idle"}, {busy_u, busy_s}, 2'b00);
        chk({tag, "_flg_u"}, flg_u, fu);
        chk({tag, "_flg_s"}, flg_s, fs);
    endtask

    initial begin
        int cyc, ndone, dcyc;

        // Reset defaults
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_done", {busy_u, done_u, busy_s, done_s}, 4'b0);
        chk("rst_flags", {flg_u, flg_s}, 12'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MSB differs: unsigned 129>8, signed -127<8
        run(8'h81, 8'h08, 1, F_GT, F_LT, "msb");
        @(posedge clk); #1;
        // Mid-word difference at bit 4
        run(8'h40, 8'h50, 4, F_LT, F_LT, "mid");
        @(posedge clk); #1;
        // Both negative when signed: 255>128, -1>-128
        run(8'hFF, 8'h80, 2, F_GT, F_GT, "neg");
        @(posedge clk); #1;
        // Only bit 0 differs: full latency
        run(8'h08, 8'h09, 8, F_LT, F_LT, "bit0");
        @(posedge clk); #1;
        // Equal operands, then back-to-back start in the done cycle
        run(8'h00, 8'h00, 8, F_EQ, F_EQ, "eq0");
        run(8'h03, 8'h02, 8, F_GT, F_GT, "b2b");
        @(posedge clk); #1;

        // start while busy is ignored
        x = 8'h5A; y = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; ndone = 0; dcyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done_u) begin ndone++; dcyc = cyc; end
            if (cyc < 8) chk("ign_flags_hold", flg_u, F_GT);
            if (cyc == 2) begin start = 1'b1; x = 8'hFF; y = 8'h00; end
            if (cyc == 3) start = 1'b0;
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_dcyc", dcyc, 8);
        chk("ign_flg", {flg_u, flg_s}, {F_EQ, F_EQ});

        // Abort mid-scan with async reset
        x = 8'h00; y = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abt_busy_pre", busy_u, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abt_async", {busy_u, done_u, busy_s, done_s}, 4'b0);
        chk("abt_flags", {flg_u, flg_s}, 12'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done_u || done_s || busy_u) ndone++;
        end
        chk("abt_no_done", ndone, 0);
        chk("abt_flags_after", {flg_u, flg_s}, 12'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
